spi_slave: RTL

SPI target-side endpoint that connects a system-clock domain to an external SPI bus. It oversamples the bus pins on `clk`, reassembles each MOSI word into `rx_data`, and shifts a preloaded `tx_data` word out on MISO. It shares CPOL/CPHA/data_width semantics with the bus master, so master and slave instantiated with identical parameters interoperate directly.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave_pin_sync.sv | 55 +++++
 rtl/spi_slave.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding, SCLK edge-select helpers
// and the minimum clk/SCLK oversampling ratio.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } spi_state_e;

    localparam int MIN_OVERSAMPLE = 8;

    // CPOL=0 idles low so the leading edge is rising; CPHA=0 samples on the leading edge.
    localparam bit CPOL_IDLE_LOW    = 1'b0;
    localparam bit CPHA_SAMPLE_LEAD = 1'b0;

    function automatic logic pick_edge(input logic sel_fall, input logic rise, input logic fall);
        return sel_fall ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side word interface of the SPI slave (transmit buffer, receive word, status).
// frame_err exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_if #(
    parameter int data_width = 8
);
    logic [data_width-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_ready;
    logic [data_width-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                  frame_err;

    modport slave  (input tx_data, tx_load, output tx_ready, rx_data, rx_valid, busy, frame_err);
    modport master (output tx_data, tx_load, input tx_ready, rx_data, rx_valid, busy, frame_err);
`else
    modport slave  (input tx_data, tx_load, output tx_ready, rx_data, rx_valid, busy);
    modport master (output tx_data, tx_load, input tx_ready, rx_data, rx_valid, busy);
`endif
endinterface

// File: rtl/spi_slave_pin_sync.sv
// Synchronizes the asynchronous SPI pins into the clk domain and derives
// mode-dependent sample/shift strobes plus chip-select edges.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic mosi_s,
    output logic cs_s,
    output logic sample_en,
    output logic shift_en,
    output logic cs_fall,
    output logic cs_rise
);

    logic [2:0] r_sclk_pipe;
    logic [2:0] r_cs_pipe;
    logic [1:0] r_mosi_pipe;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_lead;
    logic       w_trail;

    // Reset to the idle pin levels so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_pipe <= {3{CPOL}};
            r_cs_pipe   <= 3'b111;
            r_mosi_pipe <= 2'b00;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[1:0], sclk};
            r_cs_pipe   <= {r_cs_pipe[1:0], cs_n};
            r_mosi_pipe <= {r_mosi_pipe[0], mosi};
        end
    end

    assign w_sclk_rise = r_sclk_pipe[1] & ~r_sclk_pipe[2];
    assign w_sclk_fall = ~r_sclk_pipe[1] & r_sclk_pipe[2];
    assign w_lead      = pick_edge(CPOL != CPOL_IDLE_LOW, w_sclk_rise, w_sclk_fall);
    assign w_trail     = pick_edge(CPOL == CPOL_IDLE_LOW, w_sclk_rise, w_sclk_fall);

    assign sample_en = (CPHA == CPHA_SAMPLE_LEAD) ? w_lead : w_trail;
    assign shift_en  = (CPHA == CPHA_SAMPLE_LEAD) ? w_trail : w_lead;
    assign cs_fall   = ~r_cs_pipe[1] & r_cs_pipe[2];
    assign cs_rise   = r_cs_pipe[1] & ~r_cs_pipe[2];
    assign cs_s      = r_cs_pipe[1];
    assign mosi_s    = r_mosi_pipe[1];

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled pins, IDLE/SHIFT/DONE word FSM, single-entry tx buffer.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err pulse (truncated word or tx underrun).
module spi_slave
    import spi_pkg::*;
#(
    parameter int data_width = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    spi_slave_if.slave  bus
);

    localparam int                CNT_W    = $clog2(data_width + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_width - 1);

    spi_state_e            r_state;
    spi_state_e            w_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [data_width-1:0] r_rx_shift;
    logic [data_width-1:0] r_rx_data;
    logic [data_width-1:0] r_tx_buf;
    logic [data_width-1:0] r_tx_shift;
    logic                  r_rx_valid;
    logic                  r_tx_empty;
    logic                  r_miso_oe;
    logic                  w_mosi_s;
    logic                  w_cs_s;
    logic                  w_sample_en;
    logic                  w_shift_en;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_last;
    logic                  w_take;

    spi_pin_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .mosi_s    (w_mosi_s),
        .cs_s      (w_cs_s),
        .sample_en (w_sample_en),
        .shift_en  (w_shift_en),
        .cs_fall   (w_cs_fall),
        .cs_rise   (w_cs_rise)
    );

    assign w_last = (r_state == SHIFT) && w_sample_en && (r_bit_cnt == LAST_BIT);

    // CPHA=0 presents the MSB before the first edge; CPHA=1 loads on the first leading edge.
    assign w_take = (CPHA == CPHA_SAMPLE_LEAD)
                  ? (((r_state == IDLE) && w_cs_fall) || ((r_state == DONE) && !w_cs_s))
                  : ((r_state == SHIFT) && w_shift_en && (r_bit_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A final sample wins over a simultaneous cs_n rise so the word still completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
                     else if (w_cs_rise) w_next = IDLE;
            DONE:    w_next = w_cs_s ? IDLE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    // With bit_cnt at zero, CPHA=0 sees the trailing edge of the previous word, which
    // must not disturb the freshly loaded MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_buf   <= '0;
            r_tx_empty <= 1'b1;
            r_tx_shift <= '0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_rx_valid <= (r_state == DONE);
            r_miso_oe  <= ~w_cs_s;

            if (r_state != SHIFT) begin
                r_bit_cnt <= '0;
            end else if (w_sample_en) begin
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                r_rx_shift <= {r_rx_shift[data_width-2:0], w_mosi_s};
                if (w_last) r_rx_data <= {r_rx_shift[data_width-2:0], w_mosi_s};
            end

            if (w_take) begin
                r_tx_shift <= r_tx_empty ? '0 : r_tx_buf;
            end else if ((r_state == SHIFT) && w_shift_en && (r_bit_cnt != '0)) begin
                r_tx_shift <= {r_tx_shift[data_width-2:0], 1'b0};
            end

            if (bus.tx_load) begin
                r_tx_buf   <= bus.tx_data;
                r_tx_empty <= 1'b0;
            end else if (w_take) begin
                r_tx_buf   <= '0;
                r_tx_empty <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= ((r_state == SHIFT) && w_cs_rise && (r_bit_cnt != '0) && !w_last)
                         || (w_take && r_tx_empty);
        end
    end

    assign bus.frame_err = r_frame_err;
`endif

    assign miso         = r_miso_oe & r_tx_shift[data_width-1];
    assign miso_oe      = r_miso_oe;
    assign bus.tx_ready = r_tx_empty;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = (r_state != IDLE);

endmodule
